bus_select_encoder: RTL and testbench
=====================================

# bus_select_encoder

Registered encoder on the drive side of the CPU's 32-bit internal bus. It takes one-hot "out" strobes from the control unit through a valid/ready handshake and produces the 5-bit source-select code that the bus multiplexer decodes. It holds the code while the destination stalls, and it flags multi-driver conflicts. It sits between the control unit and the bus multiplexer, so that no two sources are ever selected at once.

## Interface
Parameters:
- `NSRC`, default 24: number of bus sources; fixed by the package source map.
- `CNT_W`, default 8: width of the conflict counter.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `clear_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, 1: the control unit presents a drive request.
- `req_src`, in, NSRC: drive strobes, bit i = source code i; expected to be one-hot.
- `req_ready`, out, 1: the encoder accepts `req_src` this cycle.
- `bus_stall`, in, 1: the destination is not capturing the bus; hold the current select.
- `bus_sel`, out, 5: select code to the bus multiplexer.
- `bus_drive`, out, 1: `bus_sel` is meaningful this cycle.
- `conflict`, out, 1: one-cycle pulse; the last accepted request had two or more bits set.
- `empty_req`, out, 1: one-cycle pulse; the last accepted request had zero bits set.
- `conflict_cnt`, out, CNT_W: saturating count of conflicts since reset.

## Operation
- Source map, from the package:
  - R0..R15 = 0..15
  - HI = 16, LO = 17
  - ZHI = 18, ZLO = 19
  - PC = 20, MDR = 21
  - INPORT = 22, CSIGN = 23
  - SEL_IDLE = 31
- Accept condition: `req_valid & req_ready`.
- Encoding is fixed priority: the lowest set bit wins.
- Two-state FSM:
  - IDLE: `bus_drive` = 0, `bus_sel` = SEL_IDLE, `req_ready` = 1.
    - On accept with a non-zero `req_src`: register the code and go to DRIVE.
    - On accept with a zero `req_src`: pulse `empty_req` and stay in IDLE.
  - DRIVE: `bus_drive` = 1, `bus_sel` = registered code, `req_ready` = `!bus_stall`.
    - `bus_stall` = 1: hold the code and the state; no accept.
    - `bus_stall` = 0 with an accept of a non-zero request: load the new code back-to-back and stay in DRIVE.
    - `bus_stall` = 0 with an accept of a zero request: pulse `empty_req` and go to IDLE.
    - `bus_stall` = 0 with no accept: go to IDLE.
- Conflict handling: a popcount of `req_src` ≥ 2 on accept pulses `conflict` the next cycle.
  - `conflict_cnt` increments by 1 and saturates at 2^CNT_W−1.
  - The request is still driven using the priority winner.
- `req_ready` is combinational from state, `bus_stall` and `clear_n`. It is 0 whenever `clear_n` = 0.
- Bits of `req_src` at index ≥ NSRC are not representable; the port width equals NSRC.

## Timing
- Reset value on the edge where `clear_n` = 0, and held while it stays low:
  - state = IDLE
  - `bus_sel` = 5'd31, `bus_drive` = 0
  - `conflict` = 0, `empty_req` = 0
  - `conflict_cnt` = 0
- Reset mid-DRIVE drops the in-flight select; there is no completion pulse.
- Latency: a request accepted at edge N appears on `bus_sel`/`bus_drive` from edge N through cycle N+1. Outputs are registered.
- Throughput is one transfer per cycle when `bus_stall` = 0.
- `conflict` and `empty_req` assert in the cycle after the accepting edge, for exactly one cycle.
- Stall arriving in the same cycle as a new request: no accept, and the current select is held.
- Counter at saturation: a further conflict still pulses `conflict`, but the count does not change.

## Configuration
- `BUS_ENC_CONFLICT_CNT_EN` defined: the `conflict_cnt` register and its incrementer are built as specified.
- Not defined: `conflict_cnt` is tied to 0 and no counter logic is synthesised. The `conflict` pulse remains.

## Structure
- Shared package `bus_pkg` contains:
  - source-code localparams (SRC_R0..SRC_CSIGN, SEL_IDLE)
  - NSRC
  - FSM state typedef `bus_enc_state_t` {IDLE, DRIVE}
- The bus multiplexer decodes using the same package constants.
- One sub-module, `prio_enc24`: combinational lowest-index priority encoder producing `code[4:0]`, `any` and `multi` (popcount ≥ 2).
- The top level holds the FSM, the output registers and the counter.

## Test plan
- Reset: hold `clear_n` = 0 for 2 cycles during DRIVE. Expect `bus_sel` = 31, `bus_drive` = 0, `conflict_cnt` = 0 and `req_ready` = 0 while low.
- Single transfer: `req_src` = 1<<20 (PC), valid for 1 cycle from IDLE. Expect `bus_sel` = 20 with `bus_drive` = 1 for exactly one cycle, then IDLE.
- Back-to-back with stall: R3 then MDR, with `bus_stall` = 1 for 2 cycles after the first accept. Expect `bus_sel` = 3 held for 3 cycles, `req_ready` = 0 during the stall, then 21.
- Conflict: `req_src` = bits 5 and 9. Expect `bus_sel` = 5, a `conflict` pulse and `conflict_cnt` 0→1. Repeat 300 times: the count saturates at 255.
- Empty request: `req_src` = 0 with valid in DRIVE and no stall. Expect an `empty_req` pulse, `bus_drive` = 0 and `bus_sel` = 31 the next cycle.
- Macro off: rerun the conflict case. Expect the `conflict` pulse and `conflict_cnt` constantly 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus source map and encoder FSM state type; the bus multiplexer decodes
// the same constants that the encoder produces.
package bus_pkg;

  localparam int NSRC = 24;

  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R1     = 5'd1;
  localparam logic [4:0] SRC_R2     = 5'd2;
  localparam logic [4:0] SRC_R3     = 5'd3;
  localparam logic [4:0] SRC_R4     = 5'd4;
  localparam logic [4:0] SRC_R5     = 5'd5;
  localparam logic [4:0] SRC_R6     = 5'd6;
  localparam logic [4:0] SRC_R7     = 5'd7;
  localparam logic [4:0] SRC_R8     = 5'd8;
  localparam logic [4:0] SRC_R9     = 5'd9;
  localparam logic [4:0] SRC_R10    = 5'd10;
  localparam logic [4:0] SRC_R11    = 5'd11;
  localparam logic [4:0] SRC_R12    = 5'd12;
  localparam logic [4:0] SRC_R13    = 5'd13;
  localparam logic [4:0] SRC_R14    = 5'd14;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;
  localparam logic [4:0] SEL_IDLE   = 5'd31;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } bus_enc_state_t;

endpackage

// File: rtl/prio_enc24.sv
// Combinational lowest-index priority encoder over the drive strobes, with
// "any bit set" and "two or more bits set" flags.
module prio_enc24 #(
  parameter int N = 24
) (
  input  logic [N-1:0] src,
  output logic [4:0]   code,
  output logic         any,
  output logic         multi
);

  always_comb begin
    code  = '0;
    any   = 1'b0;
    multi = 1'b0;
    // Ascending scan: the first hit sets the code, any later hit marks a conflict.
    for (int i = 0; i < N; i++) begin
      if (src[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          code = 5'(i);
        end
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_select_encoder.sv
// Registered one-hot to source-select encoder for the internal bus, with stall
// hold and conflict detection. Define BUS_ENC_CONFLICT_CNT_EN to build the conflict counter.
module bus_select_encoder #(
  parameter int NSRC  = bus_pkg::NSRC,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             req_valid,
  input  logic [NSRC-1:0]  req_src,
  output logic             req_ready,
  input  logic             bus_stall,
  output logic [4:0]       bus_sel,
  output logic             bus_drive,
  output logic             conflict,
  output logic             empty_req,
  output logic [CNT_W-1:0] conflict_cnt
);
  import bus_pkg::*;

  bus_enc_state_t stateReg;
  bus_enc_state_t stateNext;
  logic [4:0]     selReg;
  logic [4:0]     selNext;
  logic           conflictReg;
  logic           emptyReg;
  logic [4:0]     encCode;
  logic           encAny;
  logic           encMulti;
  logic           accept;

  prio_enc24 #(
    .N(NSRC)
  ) u_prioEnc (
    .src  (req_src),
    .code (encCode),
    .any  (encAny),
    .multi(encMulti)
  );

  // Ready is forced low during reset so nothing is accepted on a clearing edge.
  assign req_ready = clear_n & ((stateReg == IDLE) | ~bus_stall);
  assign accept    = req_valid & req_ready;

  always_comb begin
    stateNext = stateReg;
    selNext   = selReg;
    case (stateReg)
      IDLE: begin
        selNext = SEL_IDLE;
        if (accept && encAny) begin
          stateNext = DRIVE;
          selNext   = encCode;
        end
      end
      DRIVE: begin
        if (!bus_stall) begin
          if (accept && encAny) begin
            stateNext = DRIVE;
            selNext   = encCode;
          end else begin
            stateNext = IDLE;
            selNext   = SEL_IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        selNext   = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      stateReg    <= IDLE;
      selReg      <= SEL_IDLE;
      conflictReg <= 1'b0;
      emptyReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      selReg      <= selNext;
      conflictReg <= accept & encMulti;
      emptyReg    <= accept & ~encAny;
    end
  end

  assign bus_sel   = selReg;
  assign bus_drive = (stateReg == DRIVE);
  assign conflict  = conflictReg;
  assign empty_req = emptyReg;

`ifdef BUS_ENC_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cntReg;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      cntReg <= '0;
    end else if (accept && encMulti && (cntReg != {CNT_W{1'b1}})) begin
      cntReg <= cntReg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign conflict_cnt = cntReg;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_select_encoder.sv
// Directed self-checking bench for bus_select_encoder; conflict-count expectations
// follow whether BUS_ENC_CONFLICT_CNT_EN is defined for the build.
module tb_bus_select_encoder;

`ifdef BUS_ENC_CONFLICT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clock = 1'b0;
  logic        clear_n;
  logic        req_valid;
  logic [23:0] req_src;
  logic        req_ready;
  logic        bus_stall;
  logic [4:0]  bus_sel;
  logic        bus_drive;
  logic        conflict;
  logic        empty_req;
  logic [7:0]  conflict_cnt;

  int errors = 0;
  int checks = 0;

  bus_select_encoder #(
    .NSRC (24),
    .CNT_W(8)
  ) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .req_valid   (req_valid),
    .req_src     (req_src),
    .req_ready   (req_ready),
    .bus_stall   (bus_stall),
    .bus_sel     (bus_sel),
    .bus_drive   (bus_drive),
    .conflict    (conflict),
    .empty_req   (empty_req),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; req_valid = 1'b0; req_src = '0; bus_stall = 1'b0;
    step(); step();
    checks++; if (bus_sel !== 5'd31 || bus_drive !== 1'b0) begin errors++;
      $display("FAIL reset_init sel=%0d drive=%0b want sel=31 drive=0", bus_sel, bus_drive); end
    clear_n = 1'b1;
    // Enter DRIVE with R4, then clear during the stalled drive
    req_valid = 1'b1; req_src = 24'h1 << 4;
    step();
    checks++; if (bus_sel !== 5'd4 || bus_drive !== 1'b1) begin errors++;
      $display("FAIL reset_pre_drive sel=%0d drive=%0b want sel=4 drive=1", bus_sel, bus_drive); end
    clear_n = 1'b0; bus_stall = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready_low ready=%0b want 0", req_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus_sel !== 5'd31 || bus_drive !== 1'b0 || conflict_cnt !== 8'd0 || req_ready !== 1'b0) begin errors++;
        $display("FAIL reset_hold%0d sel=%0d drive=%0b cnt=%0d ready=%0b want 31/0/0/0",
                 i, bus_sel, bus_drive, conflict_cnt, req_ready); end
    end
    req_valid = 1'b0; req_src = '0; bus_stall = 1'b0; clear_n = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_src = 24'h1 << 20;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL single_ready ready=%0b want 1", req_ready); end
    step();
    req_valid = 1'b0; req_src = '0;
    checks++; if (bus_sel !== 5'd20 || bus_drive !== 1'b1) begin errors++;
      $display("FAIL single_drive sel=%0d drive=%0b want sel=20 drive=1", bus_sel, bus_drive); end
    step();
    checks++; if (bus_sel !== 5'd31 || bus_drive !== 1'b0) begin errors++;
      $display("FAIL single_idle sel=%0d drive=%0b want sel=31 drive=0", bus_sel, bus_drive); end
    $display("single: PC transfer sel=20");
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_src = 24'h1 << 3;
    step();
    bus_stall = 1'b1; req_src = 24'h1 << 21;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus_sel !== 5'd3 || bus_drive !== 1'b1 || req_ready !== 1'b0) begin errors++;
        $display("FAIL b2b_stall%0d sel=%0d drive=%0b ready=%0b want 3/1/0", i, bus_sel, bus_drive, req_ready); end
      step();
    end
    bus_stall = 1'b0;
    #1;
    checks++; if (bus_sel !== 5'd3 || req_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_release sel=%0d ready=%0b want 3/1", bus_sel, req_ready); end
    step();
    req_valid = 1'b0; req_src = '0;
    checks++; if (bus_sel !== 5'd21 || bus_drive !== 1'b1) begin errors++;
      $display("FAIL b2b_mdr sel=%0d drive=%0b want 21/1", bus_sel, bus_drive); end
    step();
    checks++; if (bus_drive !== 1'b0) begin errors++;
      $display("FAIL b2b_idle drive=%0b want 0", bus_drive); end
    $display("back_to_back: R3 held through stall then MDR");
  endtask

  task automatic test_conflict();
    req_valid = 1'b1; req_src = (24'h1 << 5) | (24'h1 << 9);
    step();
    req_valid = 1'b0; req_src = '0;
    checks++; if (bus_sel !== 5'd5 || conflict !== 1'b1 || conflict_cnt !== 8'(CNT_ON)) begin errors++;
      $display("FAIL conflict_first sel=%0d conflict=%0b cnt=%0d want 5/1/%0d", bus_sel, conflict, conflict_cnt, CNT_ON); end
    step();
    checks++; if (conflict !== 1'b0 || conflict_cnt !== 8'(CNT_ON)) begin errors++;
      $display("FAIL conflict_pulse_end conflict=%0b cnt=%0d want 0/%0d", conflict, conflict_cnt, CNT_ON); end
    // 300 more back-to-back conflicting accepts drive the count into saturation
    req_valid = 1'b1; req_src = (24'h1 << 5) | (24'h1 << 9);
    for (int i = 0; i < 300; i++) step();
    checks++; if (conflict !== 1'b1 || conflict_cnt !== 8'(255 * CNT_ON) || bus_sel !== 5'd5) begin errors++;
      $display("FAIL conflict_sat conflict=%0b cnt=%0d sel=%0d want 1/%0d/5", conflict, conflict_cnt, bus_sel, 255 * CNT_ON); end
    req_valid = 1'b0; req_src = '0;
    step();
    checks++; if (conflict !== 1'b0 || conflict_cnt !== 8'(255 * CNT_ON)) begin errors++;
      $display("FAIL conflict_sat_hold conflict=%0b cnt=%0d want 0/%0d", conflict, conflict_cnt, 255 * CNT_ON); end
    step();
    $display("conflict: cnt=%0d after saturation run", conflict_cnt);
  endtask

  task automatic test_priority();
    req_valid = 1'b1; req_src = 24'hFFFFFF;
    step();
    req_src = 24'h1 << 23;
    checks++; if (bus_sel !== 5'd0 || conflict !== 1'b1) begin errors++;
      $display("FAIL prio_all sel=%0d conflict=%0b want 0/1", bus_sel, conflict); end
    step();
    req_valid = 1'b0; req_src = '0;
    checks++; if (bus_sel !== 5'd23 || conflict !== 1'b0 || conflict_cnt !== 8'(255 * CNT_ON)) begin errors++;
      $display("FAIL prio_csign sel=%0d conflict=%0b cnt=%0d want 23/0/%0d", bus_sel, conflict, conflict_cnt, 255 * CNT_ON); end
    step();
    $display("priority: all-ones -> 0, CSIGN -> 23");
  endtask

  task automatic test_empty();
    req_valid = 1'b1; req_src = 24'h1 << 1;
    step();
    req_src = '0;
    step();
    req_valid = 1'b0;
    checks++; if (empty_req !== 1'b1 || bus_drive !== 1'b0 || bus_sel !== 5'd31) begin errors++;
      $display("FAIL empty_drive empty=%0b drive=%0b sel=%0d want 1/0/31", empty_req, bus_drive, bus_sel); end
    step();
    checks++; if (empty_req !== 1'b0) begin errors++;
      $display("FAIL empty_pulse_end empty=%0b want 0", empty_req); end
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++; if (empty_req !== 1'b1 || bus_drive !== 1'b0 || bus_sel !== 5'd31) begin errors++;
      $display("FAIL empty_idle empty=%0b drive=%0b sel=%0d want 1/0/31", empty_req, bus_drive, bus_sel); end
    step();
    $display("empty: pulses seen from DRIVE and IDLE");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_conflict();
    test_priority();
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
